mp3_ser: RTL

MP3_SER -- requirements
Module: mp3_ser

---
 rtl/mp3_ser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mp3_ser.sv
// Byte-to-serial transmitter for an MP3 decoder data port: one-byte holding
// register, DREQ-gated byte starts, MSB-first shifting with a sync flag on bit 7.
module mp3_ser #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mp3_req,
  output logic       mp3_clk,
  output logic       mp3_sync,
  output logic       mp3_dat,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam logic [7:0] PHASE_LOAD = 8'(CLK_DIV - 1);

  state_t     r_state, w_state_nxt;
  logic       r_req_m, r_req_s;
  logic [7:0] r_hold;
  logic       r_hold_full, w_hold_full_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_phase, w_phase_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic       r_mp3_clk, w_mp3_clk_nxt;
  logic       r_mp3_sync, w_mp3_sync_nxt;
  logic       r_mp3_dat, w_mp3_dat_nxt;
  logic       w_load, w_expired, w_start;

  assign in_ready  = !r_hold_full && !rst;
  assign w_load    = in_valid && in_ready;
  assign w_expired = (r_phase == 8'd0);
  // A byte may only begin from IDLE or exactly at the end of the last bit, so
  // a DREQ drop mid-byte can never stretch or abort the byte in flight.
  assign w_start   = r_hold_full && r_req_s &&
                     ((r_state == IDLE) ||
                      ((r_state == HIGH) && w_expired && (r_bit == 3'd0)));

  // NOTE: every next-state signal gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_full_nxt = r_hold_full;
    w_shift_nxt     = r_shift;
    w_phase_nxt     = r_phase;
    w_bit_nxt       = r_bit;
    w_mp3_clk_nxt   = r_mp3_clk;
    w_mp3_sync_nxt  = r_mp3_sync;
    w_mp3_dat_nxt   = r_mp3_dat;

    if (w_load) w_hold_full_nxt = 1'b1;

    unique case (r_state)
      IDLE: begin
        w_mp3_clk_nxt  = 1'b0;
        w_mp3_sync_nxt = 1'b0;
      end
      LOW: begin
        if (w_expired) begin
          w_mp3_clk_nxt = 1'b1;
          w_phase_nxt   = PHASE_LOAD;
          w_state_nxt   = HIGH;
        end else begin
          w_phase_nxt = r_phase - 8'd1;
        end
      end
      HIGH: begin
        if (!w_expired) begin
          w_phase_nxt = r_phase - 8'd1;
        end else if (r_bit != 3'd0) begin
          w_mp3_clk_nxt  = 1'b0;
          w_shift_nxt    = {r_shift[6:0], 1'b0};
          w_mp3_dat_nxt  = r_shift[6];
          w_mp3_sync_nxt = 1'b0;
          w_bit_nxt      = r_bit - 3'd1;
          w_phase_nxt    = PHASE_LOAD;
          w_state_nxt    = LOW;
        end else begin
          w_mp3_clk_nxt  = 1'b0;
          w_mp3_sync_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Byte start overrides the idle/end-of-byte behaviour chosen above.
    if (w_start) begin
      w_hold_full_nxt = 1'b0;
      w_shift_nxt     = r_hold;
      w_mp3_dat_nxt   = r_hold[7];
      w_mp3_sync_nxt  = 1'b1;
      w_mp3_clk_nxt   = 1'b0;
      w_bit_nxt       = 3'd7;
      w_phase_nxt     = PHASE_LOAD;
      w_state_nxt     = LOW;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_m     <= 1'b0;
      r_req_s     <= 1'b0;
      r_hold_full <= 1'b0;
      r_phase     <= 8'd0;
      r_bit       <= 3'd0;
      r_mp3_clk   <= 1'b0;
      r_mp3_sync  <= 1'b0;
      r_mp3_dat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_m     <= mp3_req;
      r_req_s     <= r_req_m;
      r_hold_full <= w_hold_full_nxt;
      r_phase     <= w_phase_nxt;
      r_bit       <= w_bit_nxt;
      r_mp3_clk   <= w_mp3_clk_nxt;
      r_mp3_sync  <= w_mp3_sync_nxt;
      r_mp3_dat   <= w_mp3_dat_nxt;
    end
  end

  // NOTE: byte storage is left unreset; its contents are only ever consumed
  // when qualified by hold_full or the FSM state, which are reset.
  always_ff @(posedge clk) begin
    if (w_load) r_hold <= in_data;
    r_shift <= w_shift_nxt;
  end

  assign mp3_clk  = r_mp3_clk;
  assign mp3_sync = r_mp3_sync;
  assign mp3_dat  = r_mp3_dat;
  assign busy     = (r_state != IDLE) || r_hold_full;

endmodule
